mac_array: RTL

- Multi-lane, parametrised successor to the single multiply-accumulate cell in the conv engine.
- One neuron value is broadcast to LANES parallel multipliers, and each lane has its own weight. Each lane accumulates a configurable number of products per output window.
- Completed windows are emitted through a valid/ready output register.
- Sits between the neuron/weight buffers and the activation/pooling stage. Replaces per-PE mac instances with one vectorised, back-pressurable unit.

---
 rtl/mac_array.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mac_array.sv
// ---------------------------------------------------------------------------
// mac_array -- vectorised multiply-accumulate unit.
//
// One neuron operand goes to LANES multipliers. Each lane has its own weight.
// Each lane accumulates cfg_acc_len products per window. A finished window
// is presented on a valid/ready output register.
//
// Pipeline:
//   stage 1 -- registered products plus the valid/last flags
//   stage 2 -- extend the product, add it to the lane accumulator, close the
//              window
//   output  -- out_acc / out_valid register
// While the output is stalled, every pipeline register holds its value.
//
// Optional build macro:
//   MAC_ARRAY_SAT_EN -- the stage-2 add saturates per lane.
//                       Without it, the add wraps modulo 2^OUT_W.
//
// Ports:
//   clk          system clock, rising edge
//   layer_reset  synchronous active-high reset
//   cfg_acc_len  products per window (0 treated as 1), sampled at window start
//   in_valid     input beat valid
//   in_ready     input beat can be taken (combinational)
//   in_last      accepted beat closes the current window early
//   neuron       broadcast operand
//   weight       lane i weight at [i*IN_W +: IN_W]
//   out_valid    out_acc holds a completed window
//   out_ready    downstream takes out_acc
//   out_acc      lane i result at [i*OUT_W +: OUT_W]
//   busy         a partial window or an in-flight product exists
// ---------------------------------------------------------------------------
module mac_array #(
   parameter int LANES  = 4,
   parameter int IN_W   = 8,
   parameter int OUT_W  = 24,
   parameter int CNT_W  = 10,
   parameter bit SIGNED = 1'b1
) (
   input  logic                   clk,
   input  logic                   layer_reset,
   input  logic [CNT_W-1:0]       cfg_acc_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_last,
   input  logic [IN_W-1:0]        neuron,
   input  logic [LANES*IN_W-1:0]  weight,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_acc,
   output logic                   busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic                   stall;
   logic                   accept;
   logic                   s1_valid_reg;
   logic                   s1_last_reg;
   logic [2*IN_W-1:0]      prod_reg [LANES];
   logic [2*IN_W-1:0]      mul_lane [LANES];
   logic [OUT_W-1:0]       acc_reg  [LANES];
   logic [OUT_W-1:0]       sum_lane [LANES];
   logic [CNT_W-1:0]       beat_cnt_reg;
   logic [CNT_W-1:0]       len_reg;
   logic [CNT_W-1:0]       cfg_len_eff;
   logic [CNT_W-1:0]       len_cur;
   logic                   close;
   logic                   out_valid_reg;
   logic [LANES*OUT_W-1:0] out_acc_reg;

   assign stall    = out_valid_reg & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;

   // The length is taken from cfg_acc_len on the first add of a window.
   // It is taken from len_reg for the rest of that window.
   assign cfg_len_eff = (cfg_acc_len == '0) ? CNT_ONE : cfg_acc_len;
   assign len_cur     = (beat_cnt_reg == '0) ? cfg_len_eff : len_reg;

   // A beat that reaches len-1 and also carries in_last closes the window once.
   assign close = s1_valid_reg & ((beat_cnt_reg == len_cur - CNT_ONE) | s1_last_reg);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [IN_W-1:0]  w_lane;
         logic [OUT_W-1:0] ext_prod;

         assign w_lane = weight[gi*IN_W +: IN_W];

         if (SIGNED) begin : g_signed
            // Both operands are sign-extended to 2*IN_W bits.
            // The low 2*IN_W bits of the product are then the exact signed result.
            assign mul_lane[gi] = $signed({{IN_W{neuron[IN_W-1]}}, neuron}) *
                                  $signed({{IN_W{w_lane[IN_W-1]}}, w_lane});
            assign ext_prod     = OUT_W'($signed(prod_reg[gi]));
         end else begin : g_unsigned
            assign mul_lane[gi] = {{IN_W{1'b0}}, neuron} * {{IN_W{1'b0}}, w_lane};
            assign ext_prod     = OUT_W'(prod_reg[gi]);
         end

`ifdef MAC_ARRAY_SAT_EN
         logic [OUT_W:0] wide_sum;
         if (SIGNED) begin : g_sat_s
            always_comb begin
               wide_sum = {acc_reg[gi][OUT_W-1], acc_reg[gi]} + {ext_prod[OUT_W-1], ext_prod};
               sum_lane[gi] = wide_sum[OUT_W-1:0];
               // The top two bits differ only when the add overflowed.
               // wide_sum[OUT_W] then gives the true sign.
               if (wide_sum[OUT_W] != wide_sum[OUT_W-1])
                  sum_lane[gi] = wide_sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                 : {1'b0, {(OUT_W-1){1'b1}}};
            end
         end else begin : g_sat_u
            always_comb begin
               wide_sum     = {1'b0, acc_reg[gi]} + {1'b0, ext_prod};
               sum_lane[gi] = wide_sum[OUT_W] ? {OUT_W{1'b1}} : wide_sum[OUT_W-1:0];
            end
         end
`else
         assign sum_lane[gi] = acc_reg[gi] + ext_prod;
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (layer_reset) begin
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         beat_cnt_reg  <= '0;
         len_reg       <= CNT_ONE;
         out_valid_reg <= 1'b0;
         out_acc_reg   <= '0;
         for (int i = 0; i < LANES; i++) begin
            prod_reg[i] <= '0;
            acc_reg[i]  <= '0;
         end
      end else if (!stall) begin
         s1_valid_reg <= accept;
         s1_last_reg  <= accept & in_last;
         if (accept) begin
            for (int i = 0; i < LANES; i++)
               prod_reg[i] <= mul_lane[i];
         end

         if (s1_valid_reg) begin
            if (beat_cnt_reg == '0)
               len_reg <= cfg_len_eff;
            if (close) begin
               beat_cnt_reg <= '0;
               for (int i = 0; i < LANES; i++) begin
                  out_acc_reg[i*OUT_W +: OUT_W] <= sum_lane[i];
                  acc_reg[i]                    <= '0;
               end
            end else begin
               beat_cnt_reg <= beat_cnt_reg + CNT_ONE;
               for (int i = 0; i < LANES; i++)
                  acc_reg[i] <= sum_lane[i];
            end
         end

         // With no stall, any held result is consumed this cycle.
         // out_valid therefore follows close directly. A result that is consumed
         // and replaced in the same cycle keeps out_valid high.
         out_valid_reg <= close;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_acc   = out_acc_reg;
   assign busy      = s1_valid_reg | (beat_cnt_reg != '0);

endmodule
